// File: rtl/add4_result_buffer_if.sv
// rtl/add4_result_buffer_if.sv - result stream between the adder, the buffer and its consumer
interface add4_result_buffer_if;
  logic       In_valid;
  logic [0:3] Sum;
  logic       Overflow;
  logic       Out_valid;
  logic       Out_ready;
  logic [4:0] Out_data;

  modport master (output In_valid, Sum, Overflow, Out_ready, input Out_valid, Out_data);
  modport slave  (input In_valid, Sum, Overflow, Out_ready, output Out_valid, Out_data);
endinterface

// File: rtl/add4_result_buffer.sv
// rtl/add4_result_buffer.sv - FIFO of {Overflow, Sum} adder results with running statistics
module add4_result_buffer #(
  parameter  int DEPTH = 4,
  parameter  int ACC_W = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Clr,
  add4_result_buffer_if.slave  bus,
  output logic                 Full,
  output logic                 Empty,
  output logic [CW-1:0]        Count,
  output logic                 Drop,
  output logic [ACC_W-1:0]     Total,
  output logic                 Total_sat,
  output logic [3:0]           Ovf_count
);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]       r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [ACC_W-1:0] r_total;
  logic             r_total_sat;
  logic [3:0]       r_ovf_count;
  logic             r_drop;

  logic [4:0]       w_in_data;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_lost;
  logic [ACC_W:0]   w_sum;

  // Sum[0] is the MSB, so plain concatenation yields the numeric value
  assign w_in_data = {bus.Overflow, bus.Sum};
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && bus.Out_ready && !Clr;
  assign w_push    = bus.In_valid && (!w_full || w_pop) && !Clr;
  assign w_lost    = bus.In_valid && w_full && !w_pop && !Clr;
  assign w_sum     = {1'b0, r_total} + (ACC_W+1)'(w_in_data);

  assign bus.Out_valid = !w_empty;
  assign bus.Out_data  = w_empty ? 5'd0 : r_mem[r_rd_ptr];
  assign Full          = w_full;
  assign Empty         = w_empty;
  assign Count         = r_count;
  assign Drop          = r_drop;
  assign Total         = r_total;
  assign Total_sat     = r_total_sat;
  assign Ovf_count     = r_ovf_count;

  // Storage needs no reset; only the pointers and count define what is valid
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else if (Clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_lost;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_total     <= '0;
      r_total_sat <= 1'b0;
      r_ovf_count <= '0;
    end else if (Clr) begin
      r_total     <= '0;
      r_total_sat <= 1'b0;
      r_ovf_count <= '0;
    end else if (w_push) begin
      // The carry out of the widened add means the clamp was needed
      if (w_sum[ACC_W]) begin
        r_total     <= '1;
        r_total_sat <= 1'b1;
      end else begin
        r_total <= w_sum[ACC_W-1:0];
      end
      if (bus.Overflow) begin
        r_ovf_count <= r_ovf_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_add4_result_buffer.sv
// tb/tb_add4_result_buffer.sv - self-checking bench for add4_result_buffer
module tb_add4_result_buffer;
  localparam int DEPTH = 4;
  localparam int ACC_W = 8;
  localparam int CW    = 3;
  localparam int TMAX  = 255;
  localparam logic [24:0] RESET_V = {1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0};

  logic             Clk   = 1'b0;
  logic             Rst_n = 1'b0;
  logic             Clr   = 1'b0;
  logic             Full;
  logic             Empty;
  logic [CW-1:0]    Count;
  logic             Drop;
  logic [ACC_W-1:0] Total;
  logic             Total_sat;
  logic [3:0]       Ovf_count;

  add4_result_buffer_if bus ();

  add4_result_buffer #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Clr       (Clr),
    .bus       (bus),
    .Full      (Full),
    .Empty     (Empty),
    .Count     (Count),
    .Drop      (Drop),
    .Total     (Total),
    .Total_sat (Total_sat),
    .Ovf_count (Ovf_count)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  int m_q[$];
  int m_total;
  bit m_sat;
  int m_ovf;
  bit m_drop;
  int d_val;
  int seen[$];

  logic [24:0] obs;
  assign obs = {bus.Out_valid, bus.Out_data, Count, Full, Empty, Drop, Total, Total_sat, Ovf_count};

  function automatic logic [24:0] expv();
    int n;
    logic [4:0] head;
    n    = m_q.size();
    head = 5'd0;
    if (n > 0) head = 5'(m_q[0]);
    return {n > 0, head, 3'(n), n == DEPTH, n == 0, m_drop, 8'(m_total), m_sat, 4'(m_ovf)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_total = 0;
    m_sat   = 1'b0;
    m_ovf   = 0;
    m_drop  = 1'b0;
  endtask

  task automatic drive(input bit v, input int val, input bit rdy);
    d_val         = val;
    bus.In_valid  = v;
    bus.Sum       = 4'(val);
    bus.Overflow  = (val >= 16);
    bus.Out_ready = rdy;
  endtask

  // Advance the reference one clock using the inputs currently applied, then step the DUT
  task automatic cyc();
    bit pop;
    bit full;
    if (!Rst_n || Clr) begin
      model_reset();
    end else begin
      pop    = (m_q.size() > 0) && bus.Out_ready;
      full   = (m_q.size() == DEPTH);
      m_drop = bus.In_valid && full && !pop;
      if (pop) begin
        seen.push_back(int'(bus.Out_data));
        void'(m_q.pop_front());
      end
      if (bus.In_valid && (!full || pop)) begin
        m_q.push_back(d_val);
        if (m_total + d_val > TMAX) begin
          m_total = TMAX;
          m_sat   = 1'b1;
        end else begin
          m_total = m_total + d_val;
        end
        if (d_val >= 16) m_ovf = (m_ovf + 1) % 16;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0);
    model_reset();
    #2;
    n_checks++;
    if (obs !== RESET_V) $display("FAIL reset_state got=%h want=%h", obs, RESET_V); else n_pass++;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1, 8, 0);
    cyc();
    drive(0, 0, 0);
    n_checks++;
    if (bus.Out_data !== 5'd8 || bus.Out_valid !== 1'b1)
      $display("FAIL single_data got=%0d/%0b want=8/1", bus.Out_data, bus.Out_valid);
    else n_pass++;
    n_checks++;
    if (Count !== 3'd1 || Total !== 8'd8 || Ovf_count !== 4'd0)
      $display("FAIL single_stats got cnt=%0d tot=%0d ovf=%0d want 1/8/0", Count, Total, Ovf_count);
    else n_pass++;
    n_checks++;
    if (obs !== expv()) $display("FAIL single_vec got=%h want=%h", obs, expv()); else n_pass++;
  endtask

  task automatic test_hold();
    drive(0, 0, 1);
    cyc();
    drive(1, 18, 0);
    cyc();
    drive(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.Out_data !== 5'd18 || bus.Out_valid !== 1'b1 || Ovf_count !== 4'd1)
        $display("FAIL hold_%0d got data=%0d ovf=%0d want 18/1", i, bus.Out_data, Ovf_count);
      else n_pass++;
      cyc();
    end
    drive(0, 0, 1);
    cyc();
    drive(0, 0, 0);
    n_checks++;
    if (Empty !== 1'b1 || bus.Out_data !== 5'd0)
      $display("FAIL hold_pop got empty=%0b data=%0d want 1/0", Empty, bus.Out_data);
    else n_pass++;
  endtask

  task automatic test_full_drop();
    int tot_before;
    for (int i = 0; i < 4; i++) begin
      drive(1, int'($urandom_range(31)), 0);
      cyc();
    end
    drive(0, 0, 0);
    n_checks++;
    if (Full !== 1'b1 || Count !== 3'd4) $display("FAIL full got full=%0b cnt=%0d want 1/4", Full, Count);
    else n_pass++;
    tot_before = m_total;
    drive(1, int'($urandom_range(31)), 0);
    cyc();
    n_checks++;
    if (Drop !== 1'b1 || Count !== 3'd4 || int'(Total) !== tot_before)
      $display("FAIL drop got drop=%0b cnt=%0d tot=%0d want 1/4/%0d", Drop, Count, Total, tot_before);
    else n_pass++;
    drive(1, int'($urandom_range(31)), 1);
    cyc();
    drive(0, 0, 0);
    n_checks++;
    if (Drop !== 1'b0 || Count !== 3'd4 || obs !== expv())
      $display("FAIL full_pushpop got=%h want=%h", obs, expv());
    else n_pass++;
    drive(0, 0, 1);
    repeat (4) cyc();
    drive(0, 0, 0);
    n_checks++;
    if (Empty !== 1'b1) $display("FAIL full_drain got empty=%0b want 1", Empty); else n_pass++;
  endtask

  task automatic test_order_wrap();
    int pushed;
    int drops;
    bit ok;
    pushed = 0;
    drops  = 0;
    seen.delete();
    for (int c = 0; c < 40 && (pushed < 10 || m_q.size() > 0); c++) begin
      if (c % 2 == 0 && pushed < 10) begin
        pushed++;
        drive(1, pushed, 0);
      end else begin
        drive(0, 0, c % 2 == 1);
      end
      cyc();
      if (Drop) drops++;
      n_checks++;
      if (obs !== expv()) $display("FAIL order_vec c=%0d got=%h want=%h", c, obs, expv()); else n_pass++;
    end
    drive(0, 0, 0);
    ok = (seen.size() == 10);
    for (int i = 0; i < seen.size() && ok; i++) ok = (seen[i] == i + 1);
    n_checks++;
    if (!ok || drops != 0) $display("FAIL order_seq got n=%0d drops=%0d want 10 in order, 0 drops", seen.size(), drops);
    else n_pass++;
  endtask

  task automatic test_saturation();
    Clr = 1'b1;
    drive(0, 0, 0);
    cyc();
    Clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1, 31, 1);
      cyc();
      if (i == 7) begin
        n_checks++;
        if (Total !== 8'd248 || Total_sat !== 1'b0)
          $display("FAIL sat_8 got tot=%0d sat=%0b want 248/0", Total, Total_sat);
        else n_pass++;
      end
    end
    drive(0, 0, 1);
    n_checks++;
    if (Total !== 8'd255 || Total_sat !== 1'b1) $display("FAIL sat_9 got tot=%0d sat=%0b want 255/1", Total, Total_sat);
    else n_pass++;
    cyc();
    cyc();
    n_checks++;
    if (Total !== 8'd255 || Total_sat !== 1'b1) $display("FAIL sat_sticky got tot=%0d sat=%0b want 255/1", Total, Total_sat);
    else n_pass++;
    Clr = 1'b1;
    drive(0, 0, 0);
    cyc();
    Clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 31, 1);
      cyc();
    end
    drive(1, 7, 1);
    cyc();
    drive(0, 0, 1);
    n_checks++;
    if (Total !== 8'd255 || Total_sat !== 1'b0) $display("FAIL sat_exact got tot=%0d sat=%0b want 255/0", Total, Total_sat);
    else n_pass++;
    cyc();
  endtask

  task automatic test_ovf_wrap();
    Clr = 1'b1;
    drive(0, 0, 0);
    cyc();
    Clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1, 16 + int'($urandom_range(15)), 1);
      cyc();
    end
    drive(0, 0, 1);
    n_checks++;
    if (Ovf_count !== 4'd1 || obs !== expv()) $display("FAIL ovf_wrap got ovf=%0d want 1 (vec %h/%h)", Ovf_count, obs, expv());
    else n_pass++;
    cyc();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) begin
      drive(1, 20 + i, 0);
      cyc();
    end
    Clr = 1'b1;
    drive(1, 5, 1);
    cyc();
    Clr = 1'b0;
    drive(0, 0, 0);
    n_checks++;
    if (Empty !== 1'b1 || Total !== 8'd0 || Ovf_count !== 4'd0 || Drop !== 1'b0 || Total_sat !== 1'b0)
      $display("FAIL clear got empty=%0b tot=%0d ovf=%0d drop=%0b want 1/0/0/0", Empty, Total, Ovf_count, Drop);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Clr = ($urandom_range(39) == 0);
      drive($urandom_range(3) != 0, int'($urandom_range(31)), $urandom_range(1) == 1);
      cyc();
      n_checks++;
      if (obs !== expv()) $display("FAIL random_%0d got=%h want=%h", i, obs, expv()); else n_pass++;
    end
    Clr = 1'b0;
    drive(0, 0, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 17 + i, 0);
      cyc();
    end
    #3;
    Rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== RESET_V) $display("FAIL async_reset got=%h want=%h", obs, RESET_V); else n_pass++;
    drive(0, 0, 0);
    cyc();
    Rst_n = 1'b1;
    drive(1, 9, 0);
    cyc();
    drive(0, 0, 0);
    n_checks++;
    if (Count !== 3'd1 || bus.Out_data !== 5'd9 || Total !== 8'd9)
      $display("FAIL post_reset got cnt=%0d data=%0d tot=%0d want 1/9/9", Count, bus.Out_data, Total);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_full_drop();
    test_order_wrap();
    test_saturation();
    test_ovf_wrap();
    test_clear();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
